// File: rtl/vm_pkg.sv
// Shared vending-machine definitions used by the change dispenser.
//   state_t : controller states IDLE, SELECT, PULSE, GAP, FINISH
//   coin_t  : which tube (if any) was picked in SELECT
//   COIN*_VALUE : dollar value of each coin, sized to the amount datapath
package vm_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SELECT = 3'd1,
        PULSE  = 3'd2,
        GAP    = 3'd3,
        FINISH = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        COIN_NONE = 2'd0,
        COIN_5    = 2'd1,
        COIN_2    = 2'd2,
        COIN_1    = 2'd3
    } coin_t;

    localparam logic [7:0] COIN5_VALUE = 8'd5;
    localparam logic [7:0] COIN2_VALUE = 8'd2;
    localparam logic [7:0] COIN1_VALUE = 8'd1;

endpackage

// File: rtl/dispense_timer.sv
// Loadable down-counter that times the eject pulse and the gap after it.
//   clk, rst_n  : clock and asynchronous active-low reset
//   load        : load load_value into the counter on this edge
//   load_value  : number of cycles to count, minus one
//   expired     : counter has reached zero (last cycle of the interval)
module dispense_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_value,
    output logic       expired
);

    logic [7:0] count;

    // Loading N-1 makes expired rise in the Nth cycle of the interval,
    // so the owner leaves its state after exactly N cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != 8'd0) begin
            count <= count - 8'd1;
        end
    end

    assign expired = (count == 8'd0);

endmodule

// File: rtl/change_dispenser.sv
// Coin change dispenser: pays an amount greedily from $5, $2 and $1 tubes,
// firing one solenoid at a time with a timed pulse and gap.
//   clk, rst_n            : clock and asynchronous active-low reset
//   start, amount         : request to pay amount dollars (accepted in IDLE)
//   refill                : fill all tubes to TUBE_MAX (accepted in IDLE)
//   busy, done            : dispensing in progress / one-cycle completion
//   short_flag, remaining : exact change failed / dollars still owed
//   eject5/2/1            : solenoid drives, at most one high at a time
//   tube5/2/1             : coins left in each tube
module change_dispenser
    import vm_pkg::*;
#(
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 2,
    parameter int TUBE_INIT    = 8,
    parameter int TUBE_MAX     = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] amount,
    input  logic       refill,
    output logic       busy,
    output logic       done,
    output logic       short_flag,
    output logic [7:0] remaining,
    output logic       eject5,
    output logic       eject2,
    output logic       eject1,
    output logic [3:0] tube5,
    output logic [3:0] tube2,
    output logic [3:0] tube1
);

    localparam logic [3:0] INIT_COUNT = 4'(TUBE_INIT);
    localparam logic [3:0] MAX_COUNT  = 4'(TUBE_MAX);
    localparam logic [7:0] PULSE_LOAD = 8'(PULSE_CYCLES - 1);
    localparam logic [7:0] GAP_LOAD   = 8'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam bit         HAS_GAP    = (GAP_CYCLES > 0);

    state_t     state, next_state;
    coin_t      pick, coin_sel;
    logic       timer_load;
    logic [7:0] timer_value;
    logic       timer_expired;

    dispense_timer u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (timer_load),
        .load_value (timer_value),
        .expired    (timer_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Greedy coin choice in SELECT; the timer is loaded on the edge that
    // enters PULSE or GAP so each interval starts counting immediately.
    always_comb begin
        next_state  = state;
        pick        = COIN_NONE;
        timer_load  = 1'b0;
        timer_value = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = SELECT;
                end
            end
            SELECT: begin
                if (remaining >= COIN5_VALUE && tube5 != 4'd0) begin
                    pick = COIN_5;
                end else if (remaining >= COIN2_VALUE && tube2 != 4'd0) begin
                    pick = COIN_2;
                end else if (remaining >= COIN1_VALUE && tube1 != 4'd0) begin
                    pick = COIN_1;
                end
                if (pick != COIN_NONE) begin
                    next_state  = PULSE;
                    timer_load  = 1'b1;
                    timer_value = PULSE_LOAD;
                end else begin
                    next_state = FINISH;
                end
            end
            PULSE: begin
                if (timer_expired) begin
                    if (HAS_GAP) begin
                        next_state  = GAP;
                        timer_load  = 1'b1;
                        timer_value = GAP_LOAD;
                    end else begin
                        next_state = SELECT;
                    end
                end
            end
            GAP: begin
                if (timer_expired) begin
                    next_state = SELECT;
                end
            end
            FINISH: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // A coin is charged (remaining and tube) on the same edge it is picked.
    // Refill and start both act in IDLE, so a combined request lets the
    // first SELECT see full tubes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining  <= '0;
            short_flag <= 1'b0;
            coin_sel   <= COIN_NONE;
            tube5      <= INIT_COUNT;
            tube2      <= INIT_COUNT;
            tube1      <= INIT_COUNT;
        end else begin
            case (state)
                IDLE: begin
                    if (refill) begin
                        tube5 <= MAX_COUNT;
                        tube2 <= MAX_COUNT;
                        tube1 <= MAX_COUNT;
                    end
                    if (start) begin
                        remaining  <= amount;
                        short_flag <= 1'b0;
                    end
                end
                SELECT: begin
                    coin_sel <= pick;
                    case (pick)
                        COIN_5: begin
                            remaining <= remaining - COIN5_VALUE;
                            tube5     <= tube5 - 4'd1;
                        end
                        COIN_2: begin
                            remaining <= remaining - COIN2_VALUE;
                            tube2     <= tube2 - 4'd1;
                        end
                        COIN_1: begin
                            remaining <= remaining - COIN1_VALUE;
                            tube1     <= tube1 - 4'd1;
                        end
                        default: begin
                            if (remaining != 8'd0) begin
                                short_flag <= 1'b1;
                            end
                        end
                    endcase
                end
                default: begin
                end
            endcase
        end
    end

    assign busy   = (state == SELECT) || (state == PULSE) || (state == GAP);
    assign done   = (state == FINISH);
    assign eject5 = (state == PULSE) && (coin_sel == COIN_5);
    assign eject2 = (state == PULSE) && (coin_sel == COIN_2);
    assign eject1 = (state == PULSE) && (coin_sel == COIN_1);

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 SHALL have parameter PULSE_CYCLES, default 4: cycles each eject line is held high per coin.
REQ-002 SHALL have parameter GAP_CYCLES, default 2: idle cycles after each eject pulse before the next selection.
REQ-003 SHALL have parameter TUBE_INIT, default 8: coins per tube after reset.
REQ-004 SHALL have parameter TUBE_MAX, default 15: coins per tube after refill; TUBE_INIT <= TUBE_MAX <= 15.
REQ-005 SHALL have port clk, input, 1: single clock; all state changes on the rising edge.
REQ-006 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1: one-cycle request to dispense amount.
REQ-008 SHALL have port amount, input, 8: change due in dollars, sampled only when start is accepted.
REQ-009 SHALL have port refill, input, 1: set all tubes to TUBE_MAX.
REQ-010 SHALL have port busy, output, 1: high from the cycle after an accepted start until done.
REQ-011 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-012 SHALL have port short_flag, output, 1: exact change could not be paid.
REQ-013 SHALL have port remaining, output, 8: dollars still owed.
REQ-014 SHALL have ports eject5, eject2 and eject1, output, 1 each: solenoid drive for the $5, $2 and $1 tubes.
REQ-015 SHALL have ports tube5, tube2 and tube1, output, 4 each: current coin count per tube.

Function
REQ-016 SHALL implement the states IDLE, SELECT, PULSE, GAP and FINISH.
REQ-017 SHALL accept start only in IDLE: latch amount into remaining, clear short_flag, and go to SELECT on the next edge; start is ignored in every other state.
REQ-018 In SELECT, SHALL pick coins greedily in this order:
  - remaining>=5 and tube5>0: $5 coin;
  - else remaining>=2 and tube2>0: $2 coin;
  - else remaining>=1 and tube1>0: $1 coin;
  - else go to FINISH.
REQ-019 SHALL set short_flag on entering FINISH when remaining is nonzero.
REQ-020 On leaving SELECT with a coin chosen, SHALL subtract the coin value from remaining, decrement that tube, and enter PULSE, all on the same edge.
REQ-021 SHALL hold exactly one eject line high for exactly PULSE_CYCLES cycles in PULSE, then hold all eject lines low for GAP_CYCLES cycles in GAP, then return to SELECT.
REQ-022 SHALL never assert two eject lines in the same cycle.
REQ-023 SHALL pulse done high for one cycle in FINISH and return to IDLE on the next edge.
REQ-024 SHALL keep short_flag and remaining stable after done until the next accepted start.
REQ-025 SHALL, for amount=0, go IDLE -> SELECT -> FINISH with no eject and short_flag=0.
REQ-026 SHALL make busy=1 exactly in SELECT, PULSE and GAP.
REQ-027 SHALL apply refill only in IDLE and ignore it in every other state.
REQ-028 When refill and start coincide in IDLE, both SHALL take effect and the first SELECT SHALL see TUBE_MAX counts.
REQ-029 SHALL never underflow a tube and never let remaining wrap below 0.
REQ-030 Per coin, SHALL spend 1+PULSE_CYCLES+GAP_CYCLES cycles; with an accepted start at cycle 0, the first eject is high in cycles 2..PULSE_CYCLES+1.

Reset
REQ-031 On rst_n low, SHALL immediately, without waiting for a clock edge, apply the following:
  - state=IDLE;
  - busy=0, done=0, short_flag=0;
  - remaining=0;
  - all eject lines=0;
  - tube5, tube2 and tube1=TUBE_INIT;
  - pulse and gap counters=0.
REQ-032 A reset mid-dispense SHALL abort at once: no further ejects, no done pulse, and any coin already charged is not restored.

Structure
REQ-033 SHALL take the state encoding (IDLE..FINISH) and the coin value constants 5, 2 and 1 from the shared package vm_pkg.
REQ-034 SHALL use one sub-module, dispense_timer: a loadable down-counter that counts PULSE_CYCLES, then GAP_CYCLES, and flags expiry.

Verification
REQ-035 Bench SHALL check: amount=8 with tubes 8/8/8 -> one eject5, one eject2, one eject1 in that order, each 4 cycles high; tubes 7/7/7; remaining=0; short_flag=0; one done pulse.
REQ-036 Bench SHALL check: amount=4 with tube2=0 and tube1=8 -> four eject1 pulses; remaining=0; tube1=4.
REQ-037 Bench SHALL check: amount=3 with tube2=0 and tube1=0 -> no ejects; done; short_flag=1; remaining=3.
REQ-038 Bench SHALL check: a second start during PULSE with amount=9 -> ignored; the original dispense completes unchanged.
REQ-039 Bench SHALL check: refill together with start in IDLE while tube5=0, amount=5 -> one eject5; tube5=14.
REQ-040 Bench SHALL check: rst_n low in the third PULSE cycle of a $5 eject -> eject5=0 at once, state=IDLE, tubes=8/8/8, and no done pulse.
